// File: rtl/board_manager.sv
// Tic-tac-toe board store: validates moves from the game controller, then walks the
// eight winning lines one per cycle to decide win, tie or continue.
module board_manager #(
    parameter int NCELLS = 9,
    parameter int NLINES = 8
) (
    input  logic       ph1,
    input  logic       reset,
    input  logic [3:0] addr,
    input  logic [1:0] cellState,
    input  logic [3:0] rdAddr,
    output logic [1:0] rdData,
    output logic       gameIsDone,
    output logic [1:0] winner,
    output logic [2:0] winLine,
    output logic       busy,
    output logic       moveReject,
    output logic [3:0] moveCount
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] NO_WRITE   = 4'hF;
    localparam logic [3:0] LAST_CELL  = 4'(NCELLS - 1);
    localparam logic [2:0] LAST_LINE  = 3'(NLINES - 1);
    localparam logic [3:0] FULL_BOARD = 4'(NCELLS);
    localparam logic [1:0] TIE_CODE   = 2'b01;

    logic [1:0] state_q, state_d;
    logic [1:0] cells_q [NCELLS];
    logic [1:0] cells_d [NCELLS];
    logic [2:0] lineIdx_q, lineIdx_d;
    logic [3:0] moveCount_q, moveCount_d;
    logic       gameIsDone_q, gameIsDone_d;
    logic [1:0] winner_q, winner_d;
    logic [2:0] winLine_q, winLine_d;
    logic       moveReject_q, moveReject_d;

    logic       writeReq;
    logic       accept;
    logic [1:0] targetCell;
    logic [3:0] idxA, idxB, idxC;
    logic [1:0] cellA, cellB, cellC;
    logic       lineMatch;

    always_comb begin
        rdData = 2'b00;
        if (rdAddr <= LAST_CELL) begin
            rdData = cells_q[rdAddr];
        end
    end

    always_comb begin
        targetCell = 2'b00;
        if (addr <= LAST_CELL) begin
            targetCell = cells_q[addr];
        end
    end

    assign writeReq = (addr != NO_WRITE);
    assign accept   = writeReq && (state_q == IDLE) && (addr <= LAST_CELL)
                      && (cellState != 2'b00) && (targetCell == 2'b00);

    // Rows, then columns, then the two diagonals; order fixes which win is reported.
    always_comb begin
        idxA = 4'd0;
        idxB = 4'd1;
        idxC = 4'd2;
        case (lineIdx_q)
            3'd0: begin idxA = 4'd0; idxB = 4'd1; idxC = 4'd2; end
            3'd1: begin idxA = 4'd3; idxB = 4'd4; idxC = 4'd5; end
            3'd2: begin idxA = 4'd6; idxB = 4'd7; idxC = 4'd8; end
            3'd3: begin idxA = 4'd0; idxB = 4'd3; idxC = 4'd6; end
            3'd4: begin idxA = 4'd1; idxB = 4'd4; idxC = 4'd7; end
            3'd5: begin idxA = 4'd2; idxB = 4'd5; idxC = 4'd8; end
            3'd6: begin idxA = 4'd0; idxB = 4'd4; idxC = 4'd8; end
            default: begin idxA = 4'd2; idxB = 4'd4; idxC = 4'd6; end
        endcase
    end

    assign cellA     = cells_q[idxA];
    assign cellB     = cells_q[idxB];
    assign cellC     = cells_q[idxC];
    assign lineMatch = (cellA != 2'b00) && (cellA == cellB) && (cellB == cellC);

    always_comb begin
        state_d      = state_q;
        cells_d      = cells_q;
        lineIdx_d    = lineIdx_q;
        moveCount_d  = moveCount_q;
        gameIsDone_d = gameIsDone_q;
        winner_d     = winner_q;
        winLine_d    = winLine_q;
        moveReject_d = writeReq && !accept;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cells_d[addr] = cellState;
                    moveCount_d   = moveCount_q + 4'd1;
                    state_d       = SCAN;
                    lineIdx_d     = 3'd0;
                end
            end
            SCAN: begin
                if (lineMatch) begin
                    state_d      = DONE;
                    gameIsDone_d = 1'b1;
                    winner_d     = cellA;
                    winLine_d    = lineIdx_q;
                end else if (lineIdx_q != LAST_LINE) begin
                    lineIdx_d = lineIdx_q + 3'd1;
                end else if (moveCount_q == FULL_BOARD) begin
                    state_d      = DONE;
                    gameIsDone_d = 1'b1;
                    winner_d     = TIE_CODE;
                    winLine_d    = 3'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            lineIdx_q    <= 3'd0;
            moveCount_q  <= 4'd0;
            gameIsDone_q <= 1'b0;
            winner_q     <= 2'b00;
            winLine_q    <= 3'd0;
            moveReject_q <= 1'b0;
            for (int i = 0; i < NCELLS; i++) begin
                cells_q[i] <= 2'b00;
            end
        end else begin
            state_q      <= state_d;
            lineIdx_q    <= lineIdx_d;
            moveCount_q  <= moveCount_d;
            gameIsDone_q <= gameIsDone_d;
            winner_q     <= winner_d;
            winLine_q    <= winLine_d;
            moveReject_q <= moveReject_d;
            for (int i = 0; i < NCELLS; i++) begin
                cells_q[i] <= cells_d[i];
            end
        end
    end

    assign busy       = (state_q == SCAN);
    assign gameIsDone = gameIsDone_q;
    assign winner     = winner_q;
    assign winLine    = winLine_q;
    assign moveReject = moveReject_q;
    assign moveCount  = moveCount_q;

endmodule

// File: tb/tb_board_manager.sv
// Scoreboard bench for board_manager: a behavioural board model predicts each move's
// immediate response and each scan's outcome and latency.
module tb_board_manager;

    logic       ph1;
    logic       reset;
    logic [3:0] addr;
    logic [1:0] cellState;
    logic [3:0] rdAddr;
    logic [1:0] rdData;
    logic       gameIsDone;
    logic [1:0] winner;
    logic [2:0] winLine;
    logic       busy;
    logic       moveReject;
    logic [3:0] moveCount;

    board_manager dut (
        .ph1       (ph1),
        .reset     (reset),
        .addr      (addr),
        .cellState (cellState),
        .rdAddr    (rdAddr),
        .rdData    (rdData),
        .gameIsDone(gameIsDone),
        .winner    (winner),
        .winLine   (winLine),
        .busy      (busy),
        .moveReject(moveReject),
        .moveCount (moveCount)
    );

    typedef struct {
        logic       rej;
        logic [3:0] cnt;
        logic       bsy;
        logic [1:0] rd;
    } moveExp_t;

    typedef struct {
        int         lat;
        logic       done;
        logic [1:0] win;
        logic [2:0] line;
    } resultExp_t;

    moveExp_t   moveQ[$];
    resultExp_t resultQ[$];

    int checks = 0;
    int errors = 0;
    int edgeCount = 0;
    int e0 = 0;

    logic [1:0] mBoard [9];
    int         mCount;
    int         mState;

    int lineCells [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
                              '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
                              '{0, 4, 8}, '{2, 4, 6}};

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    always @(posedge ph1) edgeCount <= edgeCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int firstWin();
        for (int k = 0; k < 8; k++) begin
            if (mBoard[lineCells[k][0]] != 2'b00 &&
                mBoard[lineCells[k][0]] == mBoard[lineCells[k][1]] &&
                mBoard[lineCells[k][1]] == mBoard[lineCells[k][2]]) begin
                return k;
            end
        end
        return -1;
    endfunction

    task automatic clearModel();
        for (int i = 0; i < 9; i++) mBoard[i] = 2'b00;
        mCount = 0;
        mState = 0;
        resultQ.delete();
        moveQ.delete();
    endtask

    task automatic doReset();
        addr      = 4'hF;
        cellState = 2'b00;
        rdAddr    = 4'd0;
        reset     = 1'b1;
        @(negedge ph1);
        @(negedge ph1);
        reset = 1'b0;
        clearModel();
        @(negedge ph1);
    endtask

    // Drive one write request; the expected response is queued now and checked one edge later.
    task automatic applyStimulus(input logic [3:0] a, input logic [1:0] c);
        moveExp_t   m;
        resultExp_t r;
        bit         acc;
        int         k;
        addr      = a;
        cellState = c;
        rdAddr    = a;
        acc = 1'b0;
        if (mState == 0 && a <= 4'd8 && c != 2'b00) begin
            if (mBoard[a] == 2'b00) acc = 1'b1;
        end
        if (acc) begin
            mBoard[a] = c;
            mCount++;
            mState = 1;
            k = firstWin();
            if (k >= 0) begin
                r.lat = k + 2; r.done = 1'b1; r.win = mBoard[lineCells[k][0]]; r.line = 3'(k);
            end else if (mCount == 9) begin
                r.lat = 9; r.done = 1'b1; r.win = 2'b01; r.line = 3'd0;
            end else begin
                r.lat = 9; r.done = 1'b0; r.win = 2'b00; r.line = 3'd0;
            end
            resultQ.push_back(r);
        end
        m.rej = (a != 4'hF) && !acc;
        m.cnt = 4'(mCount);
        m.bsy = (mState == 1);
        m.rd  = (a <= 4'd8) ? mBoard[a] : 2'b00;
        moveQ.push_back(m);
        @(posedge ph1);
        @(negedge ph1);
        if (acc) e0 = edgeCount;
        addr      = 4'hF;
        cellState = 2'b00;
        m = moveQ.pop_front();
        checkOutput("moveReject", 32'(moveReject), 32'(m.rej));
        checkOutput("moveCount", 32'(moveCount), 32'(m.cnt));
        checkOutput("busy", 32'(busy), 32'(m.bsy));
        checkOutput("rdData", 32'(rdData), 32'(m.rd));
    endtask

    // Follow the scan started by the last accepted move until busy drops.
    task automatic waitResult();
        resultExp_t r;
        logic       early;
        int         lat;
        if (resultQ.size() == 0) return;
        r = resultQ.pop_front();
        early = 1'b0;
        while (busy && (edgeCount - e0) < 30) begin
            if (gameIsDone) early = 1'b1;
            @(negedge ph1);
        end
        lat = edgeCount - e0 + 1;
        checkOutput("latency", 32'(lat), 32'(r.lat));
        checkOutput("doneEarly", 32'(early), 32'd0);
        checkOutput("gameIsDone", 32'(gameIsDone), 32'(r.done));
        checkOutput("winner", 32'(winner), 32'(r.win));
        checkOutput("winLine", 32'(winLine), 32'(r.line));
        checkOutput("busyEnd", 32'(busy), 32'd0);
        mState = r.done ? 2 : 0;
    endtask

    task automatic move(input logic [3:0] a, input logic [1:0] c);
        applyStimulus(a, c);
        waitResult();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        $display("[TB] start");
        doReset();
        checkOutput("rstDone", 32'(gameIsDone), 32'd0);
        checkOutput("rstWinner", 32'(winner), 32'd0);
        checkOutput("rstWinLine", 32'(winLine), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstReject", 32'(moveReject), 32'd0);
        checkOutput("rstCount", 32'(moveCount), 32'd0);

        // Player1 wins on the top row.
        move(4'd0, 2'b11);
        move(4'd4, 2'b10);
        move(4'd1, 2'b11);
        move(4'd5, 2'b10);
        move(4'd2, 2'b11);
        applyStimulus(4'd3, 2'b11);
        checkOutput("heldDone", 32'(gameIsDone), 32'd1);
        checkOutput("heldWinner", 32'(winner), 32'd3);

        // Player2 wins on the anti-diagonal, with illegal requests mixed in.
        doReset();
        move(4'd0, 2'b11);
        move(4'd2, 2'b10);
        move(4'd1, 2'b11);
        move(4'd4, 2'b10);
        applyStimulus(4'd4, 2'b11);
        applyStimulus(4'd10, 2'b11);
        applyStimulus(4'd3, 2'b00);
        applyStimulus(4'hF, 2'b11);
        move(4'd6, 2'b10);

        // Full board with no line: tie.
        doReset();
        applyStimulus(4'd0, 2'b11);
        applyStimulus(4'd3, 2'b11);
        waitResult();
        move(4'd1, 2'b10);
        move(4'd2, 2'b11);
        move(4'd4, 2'b10);
        move(4'd3, 2'b11);
        move(4'd5, 2'b10);
        move(4'd7, 2'b11);
        move(4'd6, 2'b10);
        move(4'd8, 2'b11);

        // Asynchronous reset in the middle of a scan.
        doReset();
        applyStimulus(4'd4, 2'b11);
        @(negedge ph1);
        @(negedge ph1);
        @(negedge ph1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midRstDone", 32'(gameIsDone), 32'd0);
        checkOutput("midRstWinner", 32'(winner), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstCount", 32'(moveCount), 32'd0);
        checkOutput("midRstReject", 32'(moveReject), 32'd0);
        checkOutput("midRstWinLine", 32'(winLine), 32'd0);
        for (int i = 0; i < 9; i++) begin
            rdAddr = 4'(i);
            #1;
            checkOutput("midRstCell", 32'(rdData), 32'd0);
        end
        clearModel();
        @(negedge ph1);
        reset = 1'b0;
        @(negedge ph1);
        move(4'd4, 2'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
